ring_fifo: RTL and testbench
============================

Name: ring_fifo

Overview:
- Parametrised single-clock FIFO and successor to the core's simple ring buffer, for core-side queues such as UART RX/TX and bus request buffering.
- True full at MEMORY_DEPTH entries, with a count port wide enough to represent it.
- Selectable first-word-fall-through (FWFT) or registered-read mode.
- Programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. All logic on posedge clk.

Parameters:
- DATA_WIDTH, 32, width of each entry.
- MEMORY_DEPTH, 32, number of entries; power of two, >= 2.
- FWFT, 1, 1 = head visible on dout while !empty; 0 = dout registered on accepted read.
- AFULL_THRESH, MEMORY_DEPTH-2, almost_full asserted when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents and error flags
- wr  in  1  write request
- din  in  DATA_WIDTH  write data
- rd  in  1  read request
- dout  out  DATA_WIDTH  read data
- empty  out  1  count == 0
- full  out  1  count == MEMORY_DEPTH
- almost_empty  out  1  count <= AEMPTY_THRESH
- almost_full  out  1  count >= AFULL_THRESH
- count  out  $clog2(MEMORY_DEPTH)+1  current occupancy, 0..MEMORY_DEPTH
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-low; rst=0 immediately forces the reset state regardless of clk.
- Reset state:
  - wr_ptr = rd_ptr = 0, count = 0, dout = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0.
  - Memory contents are not reset.
- Pointers:
  - $clog2(MEMORY_DEPTH)+1 bits each; the MSB is the wrap bit.
  - Memory is addressed by the low bits, so the pointers wrap modulo MEMORY_DEPTH naturally.
  - count = wr_ptr - rd_ptr (modulo 2^(AW+1)).
  - All status flags are derived combinationally from the registered pointers, so they reflect state after the last edge.
- Accept rules, evaluated each posedge:
  - rd_acc = rd & !empty.
  - wr_acc = wr & (!full | rd_acc): writing while full is allowed only with a simultaneous accepted read (pass-through; count stays MEMORY_DEPTH).
  - Simultaneous wr and rd while empty: only the write is accepted. The read is rejected and sets underflow.
- Write: on wr_acc, mem[wr_ptr] <= din and wr_ptr increments. Visible as empty = 0 on the next cycle.
- Read, FWFT = 1:
  - dout = mem[rd_ptr] combinationally and is valid whenever !empty. Its value is don't-care while empty.
  - rd_acc increments rd_ptr, so the next entry appears after the edge.
  - First-write latency to dout: 1 cycle.
- Read, FWFT = 0:
  - On rd_acc, dout <= mem[rd_ptr] and rd_ptr increments; data is valid the cycle after the request.
  - dout holds its value when there is no rd_acc.
  - Reading the last entry together with a new write returns the old head.
- Errors:
  - overflow <= 1 when wr & !wr_acc.
  - underflow <= 1 when rd & !rd_acc.
  - Both are sticky until flush or reset.
- Flush:
  - Synchronous; priority above wr and rd. Pointers go to 0 and both error flags clear.
  - wr and rd in the flush cycle are ignored and do not set the error flags.
  - dout is held in mode 0 and is don't-care in FWFT mode.
- Reset mid-operation: all state returns to the reset values asynchronously. The first accepted write after rst deasserts goes to address 0.
- Elaboration checks: MEMORY_DEPTH must be a power of two and >= 2, and 0 <= AEMPTY_THRESH < AFULL_THRESH <= MEMORY_DEPTH. A violation is an elaboration error.

Decomposition:
- ring_fifo_pkg:
  - typedef fifo_status_t, a packed struct of {empty, full, almost_empty, almost_full, overflow, underflow}, for consumers that bundle the flags.
  - A function computing the pointer width.
- Sub-module ring_fifo_mem: simple dual-port array, synchronous write, combinational read at rd_addr. ring_fifo adds the registered dout stage for FWFT = 0.

Test Plan:
- DEPTH=4, FWFT=1: write 0xA1..0xA4 on consecutive cycles -> count 1,2,3,4; full=1 after the 4th edge; almost_full=1 from count 2; dout=0xA1 one cycle after the first write.
- Full FIFO: write 0xB0 alone -> rejected, overflow=1, count=4. Then write 0xB0 with rd -> accepted, count stays 4, dout advances 0xA1 -> 0xA2.
- Empty FIFO: rd with wr(0xC5) -> underflow=1, count=1, dout=0xC5 next cycle (FWFT). FWFT=0 variant: a later rd gives dout=0xC5 one cycle later.
- Wrap-around: push/pop 10 entries 0x00..0x09 through DEPTH=4 -> output order preserved exactly; pointer wrap bit toggles; empty=1 at the end.
- Flush with count=3, overflow=1, wr=1 in the same cycle -> count=0, empty=1, overflow=0, written data discarded.
- rst=0 asserted between clock edges with count=2 -> outputs at reset values before the next posedge; after release, writing 0xD7 then reading returns 0xD7.

Source files
------------

// File: rtl/ring_fifo_pkg.sv
// ring_fifo shared types and helpers.
// Status bundle and pointer sizing.
package ring_fifo_pkg;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   // Address bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ring_fifo_mem.sv
// ring_fifo storage array.
// Synchronous write, combinational read.
module ring_fifo_mem #(
   parameter int DW    = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] din,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // Contents are never reset.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= din;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ring_fifo.sv
// ring_fifo: single-clock FIFO with true full,
// FWFT or registered read, thresholds and error flags.
module ring_fifo
   import ring_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MEMORY_DEPTH  = 32,
   parameter bit FWFT          = 1'b1,
   parameter int AFULL_THRESH  = MEMORY_DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          wr,
   input  logic [DATA_WIDTH-1:0]         din,
   input  logic                          rd,
   output logic [DATA_WIDTH-1:0]         dout,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_empty,
   output logic                          almost_full,
   output logic [$clog2(MEMORY_DEPTH):0] count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PW = ptr_w(MEMORY_DEPTH);
   localparam int AW = PW - 1;

   localparam logic [PW-1:0] FULL_C = PW'(MEMORY_DEPTH);
   localparam logic [PW-1:0] AF_C   = PW'(AFULL_THRESH);
   localparam logic [PW-1:0] AE_C   = PW'(AEMPTY_THRESH);

   if ((MEMORY_DEPTH < 2) ||
       ((MEMORY_DEPTH & (MEMORY_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("ring_fifo: MEMORY_DEPTH must be a power of two >= 2");
   end

   if ((AEMPTY_THRESH < 0) ||
       (AEMPTY_THRESH >= AFULL_THRESH) ||
       (AFULL_THRESH > MEMORY_DEPTH)) begin : g_bad_thresh
      $error("ring_fifo: need 0 <= AEMPTY < AFULL <= DEPTH");
   end

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [DATA_WIDTH-1:0] rd_data;

   assign count        = wr_ptr - rd_ptr;
   assign empty        = (count == '0);
   assign full         = (count == FULL_C);
   assign almost_empty = (count <= AE_C);
   assign almost_full  = (count >= AF_C);

   // Read wins a slot when full, enabling pass-through.
   assign rd_acc = rd & ~empty;
   assign wr_acc = wr & (~full | rd_acc);

   ring_fifo_mem #(
      .DW    (DATA_WIDTH),
      .DEPTH (MEMORY_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we      (wr_acc & ~flush),
      .wr_addr (wr_ptr[AW-1:0]),
      .din     (din),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_data)
   );

   // Pointer advance; flush rewinds both to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sticky rejection flags, cleared only by flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr & ~wr_acc) overflow  <= 1'b1;
         if (rd & ~rd_acc) underflow <= 1'b1;
      end
   end

   if (FWFT) begin : g_fwft
      assign dout = rd_data;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;

      // Capture head on an accepted read, hold otherwise.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)                 dout_q <= '0;
         else if (rd_acc & ~flush) dout_q <= rd_data;
      end

      assign dout = dout_q;
   end

endmodule

// File: tb/tb_ring_fifo.sv
// ring_fifo bench: FWFT and registered-read instances
// driven together, checked against a queue model.
module tb_ring_fifo;

   localparam int D  = 4;
   localparam int AF = 2;
   localparam int AE = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic       wr = 1'b0;
   logic       rd = 1'b0;
   logic [7:0] din = '0;

   logic [7:0] dout_f, dout_r;
   logic       empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
   logic       empty_r, full_r, ae_r, af_r, ovf_r, unf_r;
   logic [2:0] count_f, count_r;

   int checks = 0;
   int fails  = 0;

   logic [7:0] q[$];
   logic [7:0] exp_r = '0;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   always #5 clk = ~clk;

   ring_fifo #(
      .DATA_WIDTH(8), .MEMORY_DEPTH(D), .FWFT(1'b1),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) u_f (
      .clk(clk), .rst(rst), .flush(flush), .wr(wr), .din(din),
      .rd(rd), .dout(dout_f), .empty(empty_f), .full(full_f),
      .almost_empty(ae_f), .almost_full(af_f), .count(count_f),
      .overflow(ovf_f), .underflow(unf_f)
   );

   ring_fifo #(
      .DATA_WIDTH(8), .MEMORY_DEPTH(D), .FWFT(1'b0),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) u_r (
      .clk(clk), .rst(rst), .flush(flush), .wr(wr), .din(din),
      .rd(rd), .dout(dout_r), .empty(empty_r), .full(full_r),
      .almost_empty(ae_r), .almost_full(af_r), .count(count_r),
      .overflow(ovf_r), .underflow(unf_r)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_r = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step(input logic w, input logic [7:0] d,
                             input logic r, input logic f);
      bit racc, wacc;
      if (f) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         racc = r && (q.size() > 0);
         wacc = w && ((q.size() < D) || racc);
         if (racc) exp_r = q.pop_front();
         if (wacc) q.push_back(d);
         if (w && !wacc) m_ovf = 1'b1;
         if (r && !racc) m_unf = 1'b1;
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count_f", 32'(count_f), 32'(n));
      chk("count_r", 32'(count_r), 32'(n));
      chk("empty_f", 32'(empty_f), 32'(n == 0));
      chk("full_f",  32'(full_f),  32'(n == D));
      chk("aempty_f", 32'(ae_f),   32'(n <= AE));
      chk("afull_f", 32'(af_f),    32'(n >= AF));
      chk("flags_r",
          32'({empty_r, full_r, ae_r, af_r}),
          32'({n == 0, n == D, n <= AE, n >= AF}));
      chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
      chk("unf_f", 32'(unf_f), 32'(m_unf));
      chk("err_r", 32'({ovf_r, unf_r}), 32'({m_ovf, m_unf}));
      chk("dout_r", 32'(dout_r), 32'(exp_r));
      if (n > 0) chk("dout_f", 32'(dout_f), 32'(q[0]));
   endtask

   task automatic cycle(input logic w, input logic [7:0] d,
                        input logic r, input logic f);
      wr = w;
      din = d;
      rd = r;
      flush = f;
      @(posedge clk);
      model_step(w, d, r, f);
      #1;
      check_all();
      wr = 1'b0;
      rd = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_count", 32'(count_f), 0);
      chk("rst_flags",
          32'({empty_f, full_f, ae_f, af_f, ovf_f, unf_f}),
          32'(6'b101000));
      chk("rst_dout_r", 32'(dout_r), 0);
      #10 rst = 1'b1;

      for (int i = 0; i < 4; i++)
         cycle(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'hB0, 1'b0, 1'b0);
      cycle(1'b1, 8'hB0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 8'h00, 1'b1, 1'b0);

      cycle(1'b1, 8'hC5, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      for (int i = 0; i < 10; i++)
         cycle(1'b1, 8'(i), 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      for (int i = 0; i < 3; i++)
         cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'hEF, 1'b0, 1'b1);
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 8'h12, 1'b0, 1'b0);

      #3 rst = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_count", 32'(count_f), 0);
      chk("mid_rst_flags",
          32'({empty_f, full_f, ae_f, af_f, ovf_f, unf_f}),
          32'(6'b101000));
      chk("mid_rst_dout_r", 32'(dout_r), 0);
      #2 rst = 1'b1;
      cycle(1'b1, 8'hD7, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 99) < 55),
               8'($urandom),
               1'($urandom_range(0, 99) < 50),
               1'($urandom_range(0, 99) < 3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
